// File: rtl/hc595_serial_driver.sv
// Serial driver for two cascaded 74HC595 shift registers.
// Emits ds/sh_cp/st_cp frames, MSB first, repeating while enabled.
module hc595_serial_driver #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data,
    input  logic              chip_en,
    output logic              sh_cp,
    output logic              st_cp,
    output logic              ds
);

    localparam int STEPS = 2 * DATA_W + 1;
    localparam int SW    = $clog2(STEPS);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [SW-1:0] LAST_STEP = SW'(2 * DATA_W);
    localparam logic [DW-1:0] DIV_TOP   = DW'(CLK_DIV - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [SW-1:0]     step_q, step_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              ds_q, ds_d;
    logic              sh_q, sh_d;
    logic              st_q, st_d;
    logic              start;
    logic              adv;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            step_q   <= '0;
            shadow_q <= '0;
            ds_q     <= 1'b0;
            sh_q     <= 1'b0;
            st_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            step_q   <= step_d;
            shadow_q <= shadow_d;
            ds_q     <= ds_d;
            sh_q     <= sh_d;
            st_q     <= st_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        step_d   = step_q;
        shadow_d = shadow_q;
        ds_d     = ds_q;
        sh_d     = sh_q;
        st_d     = st_q;
        start    = 1'b0;
        adv      = 1'b0;

        unique case (state_q)
            IDLE: begin
                ds_d = 1'b0;
                sh_d = 1'b0;
                st_d = 1'b0;
                if (chip_en) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_TOP) begin
                    div_d = '0;
                    if (step_q != LAST_STEP) begin
                        adv = 1'b1;
                    end else if (chip_en) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                        step_d  = '0;
                        ds_d    = 1'b0;
                        sh_d    = 1'b0;
                        st_d    = 1'b0;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase

        if (start) begin
            div_d    = '0;
            step_d   = '0;
            shadow_d = data;
            ds_d     = data[DATA_W-1];
            sh_d     = 1'b0;
            st_d     = 1'b0;
        end

        // Shadow shifts left once per bit, so bit DATA_W-2 is always the next one out.
        if (adv) begin
            step_d = step_q + 1'b1;
            if (step_d == LAST_STEP) begin
                sh_d = 1'b0;
                st_d = 1'b1;
            end else if (step_d[0]) begin
                sh_d = 1'b1;
            end else begin
                sh_d     = 1'b0;
                ds_d     = shadow_q[DATA_W-2];
                shadow_d = {shadow_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign ds    = ds_q;
    assign sh_cp = sh_q;
    assign st_cp = st_q;

endmodule

// File: tb/tb_hc595_serial_driver.sv
// Bench for hc595_serial_driver: CLK_DIV=2 and CLK_DIV=4 instances
// checked cycle by cycle against a frame-arithmetic model.
module tb_hc595_serial_driver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] data = 16'hAF65;
    logic        chip_en = 1'b1;

    logic ds0, sh0, st0;
    logic ds1, sh1, st1;
    logic [2:0] o [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    hc595_serial_driver #(.DATA_W(16), .CLK_DIV(2)) u_div2 (
        .clk     (clk),
        .reset_n (reset_n),
        .data    (data),
        .chip_en (chip_en),
        .sh_cp   (sh0),
        .st_cp   (st0),
        .ds      (ds0)
    );

    hc595_serial_driver #(.DATA_W(16), .CLK_DIV(4)) u_div4 (
        .clk     (clk),
        .reset_n (reset_n),
        .data    (data),
        .chip_en (chip_en),
        .sh_cp   (sh1),
        .st_cp   (st1),
        .ds      (ds1)
    );

    assign o[0] = {st0, sh0, ds0};
    assign o[1] = {st1, sh1, ds1};

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Expected {st_cp, sh_cp, ds} t clocks into a frame of word w.
    function automatic logic [2:0] exp_out(bit act, int t, int div,
                                           logic [15:0] w);
        int s;
        if (!act) return 3'b000;
        s = t / div;
        if (s >= 32) return {1'b1, 1'b0, w[0]};
        return {1'b0, s[0], w[15 - s / 2]};
    endfunction

    bit          act [2];
    int          tcyc [2];
    logic [15:0] word [2];
    int          divs [2] = '{2, 4};

    initial begin
        logic        en_s, rst_s;
        logic [15:0] d_s;
        logic        prev_sh, prev_st;
        logic [15:0] bits;
        int          rises;
        for (int i = 0; i < 2; i++) begin
            act[i] = 0;
            tcyc[i] = 0;
            word[i] = '0;
        end
        prev_sh = 0;
        prev_st = 0;
        bits = '0;
        rises = 0;
        forever begin
            @(posedge clk);
            en_s = chip_en;
            d_s = data;
            rst_s = reset_n;
            for (int i = 0; i < 2; i++) begin
                if (!rst_s) begin
                    act[i] = 0;
                end else if (!act[i]) begin
                    if (en_s) begin
                        act[i] = 1;
                        tcyc[i] = 0;
                        word[i] = d_s;
                    end
                end else begin
                    tcyc[i]++;
                    if (tcyc[i] == 33 * divs[i]) begin
                        if (en_s) begin
                            tcyc[i] = 0;
                            word[i] = d_s;
                        end else begin
                            act[i] = 0;
                        end
                    end
                end
            end
            #1;
            check("div2_pins", 32'(o[0]),
                  32'(exp_out(act[0], tcyc[0], 2, word[0])));
            check("div4_pins", 32'(o[1]),
                  32'(exp_out(act[1], tcyc[1], 4, word[1])));
            if (!rst_s) begin
                bits = '0;
                rises = 0;
            end else begin
                if (!prev_sh && sh0) begin
                    bits = {bits[14:0], ds0};
                    rises++;
                end
                if (!prev_st && st0) begin
                    check("latched_word", 32'(bits), 32'(word[0]));
                    check("sh_rises", rises, 16);
                    rises = 0;
                end
            end
            prev_sh = sh0;
            prev_st = st0;
        end
    end

    initial begin
        reset_n = 1'b0;
        chip_en = 1'b1;
        data = 16'hAF65;
        repeat (20) @(negedge clk);
        check("in_reset", 32'({o[0], o[1]}), 32'd0);
        reset_n = 1'b1;

        repeat (80) @(negedge clk);
        data = 16'h55A5;
        repeat (200) @(negedge clk);

        chip_en = 1'b0;
        repeat (150) @(negedge clk);
        check("idle_after_en_off", 32'({o[0], o[1]}), 32'd0);
        chip_en = 1'b1;
        repeat (50) @(negedge clk);

        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check("async_reset", 32'({o[0], o[1]}), 32'd0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (150) @(negedge clk);

        repeat (14) begin
            data = 16'($urandom);
            chip_en = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(5, 160)) @(negedge clk);
        end

        chip_en = 1'b1;
        data = 16'($urandom);
        repeat (150) @(negedge clk);
        @(posedge clk);
        #5 reset_n = 1'b0;
        #1 check("async_reset_2", 32'({o[0], o[1]}), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hc595_serial_driver.md
Name: hc595_serial_driver

Overview:
- Serialises a 16-bit word into two cascaded 74HC595 shift registers, typically segment and digit-select bytes for a seven-segment display.
- Generates serial data (ds), shift clock (sh_cp) and latch clock (st_cp) from the system clock.
- Refreshes continuously while enabled.
- Sits between display-scan logic and the board pins.

Parameters:
- DATA_W, 16, word width and number of bits shifted per frame.
- CLK_DIV, 2, system clocks per step (half sh_cp period); must be >=1.

Ports:
- clk  input  1  system clock (50 MHz nominal); all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data  input  DATA_W  word to send; bit DATA_W-1 is shifted first and ends in the far 595's Q7.
- chip_en  input  1  enable; while high, frames repeat back-to-back.
- sh_cp  output  1  shift clock to the 595 SHCP pin.
- st_cp  output  1  storage/latch clock to the 595 STCP pin.
- ds  output  1  serial data to the 595 DS pin.

Behaviour:
- Reset (reset_n=0, asynchronous): ds=0, sh_cp=0, st_cp=0; divider, step counter and shadow register cleared; state IDLE.
- All outputs are registered and glitch-free.
- States:
  - IDLE: outputs ds=0, sh_cp=0, st_cp=0.
  - SHIFT: frame in progress.
- IDLE -> SHIFT: on the first rising edge with chip_en=1. That edge starts step 0.
- Frame structure:
  - 2*DATA_W+1 steps (33 by default), each CLK_DIV clocks long.
  - A divider counter 0..CLK_DIV-1 advances the step counter when it reaches CLK_DIV-1.
  - Each step's actions take effect on the clock edge that begins the step.
- Step 0:
  - shadow <= data; ds <= data[DATA_W-1]; sh_cp <= 0; st_cp <= 0.
- Step 2k, k = 1..DATA_W-1:
  - ds <= shadow[DATA_W-1-k]; sh_cp <= 0.
- Step 2k+1, k = 0..DATA_W-1:
  - sh_cp <= 1; ds unchanged.
  - This gives ds one full step of setup before each sh_cp rising edge.
- Step 2*DATA_W:
  - sh_cp <= 0; st_cp <= 1; ds holds its last bit.
- End of frame (after step 2*DATA_W):
  - chip_en=1: next step is step 0 of a new frame, which resamples data and drops st_cp.
  - chip_en=0: return to IDLE, clearing st_cp, ds and sh_cp.
- Data capture:
  - data is sampled only at step 0.
  - Changes mid-frame affect only the next frame.
- chip_en deasserted mid-frame: the current frame completes, including the latch pulse, so the 595 outputs never show a partial word. The block then goes IDLE.
- Timing (defaults, 50 MHz):
  - Step = 40 ns; sh_cp period 80 ns (12.5 MHz), 50% duty.
  - st_cp high pulse 40 ns.
  - Frame = 66 clocks = 1320 ns.
  - Exactly DATA_W sh_cp rising edges and one st_cp rising edge per frame.
- Latency: first sh_cp rise occurs CLK_DIV clocks after SHIFT entry; the latch rises 2*DATA_W*CLK_DIV clocks after SHIFT entry.
- Reset asserted mid-frame: immediate return to reset values; no latch pulse is produced for the aborted frame.

Test Plan:
- Reset held 20 clocks with chip_en=1, data=16'hAF65 -> ds, sh_cp and st_cp stay 0 throughout reset.
- Release reset, data=16'hAF65 -> ds sampled on each sh_cp rise reads 1010_1111_0110_0101 MSB-first. There are 16 sh_cp rises, each 80 ns apart. st_cp rises 40 ns after the 16th sh_cp rise and stays high 40 ns. Frame repeats every 1320 ns.
- Change data to 16'h55A5 mid-frame -> the current frame completes with 16'hAF65; the next frame shifts 0101_0101_1010_0101.
- Deassert chip_en mid-frame -> the frame finishes with its st_cp pulse, then all outputs stay 0. Reassert -> a new frame starts on the next clock with ds=data[15].
- Assert reset_n=0 mid-frame -> outputs go 0 asynchronously with no st_cp pulse. After release with chip_en=1, a full fresh frame follows.
- CLK_DIV=4 -> sh_cp period 160 ns, frame 132 clocks, same bit order and pulse counts.
